// File: rtl/mult_writeback_queue.sv
// Writeback queue behind the 3-stage multiplier: buffers completed products in order,
// tracks issued-but-unfinished multiplies, and publishes hazard mask and overflow stall.
module mult_writeback_queue #(
  parameter int         DEPTH      = 4,
  parameter logic [3:0] MUL_OPCODE = 4'h5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [3:0]  issue_rd,
  input  logic [15:0] product,
  input  logic [1:0]  mult_status,
  input  logic [15:0] ex_instr,
  input  logic        wb_grant,
  output logic        wb_en,
  output logic [3:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        wb_ovf,
  output logic [15:0] pending_mask,
  output logic        mult_stall,
  output logic        seq_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] res_rptr_q, res_rptr_d, res_wptr_q, res_wptr_d;
  logic [PW-1:0] tag_rptr_q, tag_rptr_d, tag_wptr_q, tag_wptr_d;
  logic [CW-1:0] res_cnt_q, res_cnt_d, tag_cnt_q, tag_cnt_d;
  logic          seq_err_q, seq_err_d;

  logic [3:0]  res_rd_q   [DEPTH];
  logic [3:0]  res_rd_d   [DEPTH];
  logic [15:0] res_data_q [DEPTH];
  logic [15:0] res_data_d [DEPTH];
  logic        res_ovf_q  [DEPTH];
  logic        res_ovf_d  [DEPTH];
  logic [3:0]  tag_rd_q   [DEPTH];
  logic [3:0]  tag_rd_d   [DEPTH];

  logic          capture, res_empty, res_full, tag_empty;
  logic          pop, res_push, tag_pop, tag_push, tag_err;
  logic [3:0]    cap_rd;
  logic [CW:0]   occupancy;
  logic [15:0]   mask;

  assign res_empty = (res_cnt_q == '0);
  assign res_full  = (res_cnt_q == DEPTH_C);
  assign tag_empty = (tag_cnt_q == '0);
  assign occupancy = {1'b0, res_cnt_q} + {1'b0, tag_cnt_q};

  always_comb begin
    capture    = mult_status[1] && (ex_instr[15:12] == MUL_OPCODE);
    cap_rd     = ex_instr[11:8];
    mult_stall = (occupancy >= {1'b0, DEPTH_C});
    pop        = !res_empty && wb_grant;
    // A full queue still accepts a capture when the head leaves on the same edge.
    res_push   = capture && (!res_full || pop);
    tag_pop    = capture && !tag_empty;
    tag_push   = issue_valid && !mult_stall;
    tag_err    = capture && (tag_empty || (tag_rd_q[tag_rptr_q] != cap_rd));

    res_rptr_d = pop      ? res_rptr_q + PW'(1) : res_rptr_q;
    res_wptr_d = res_push ? res_wptr_q + PW'(1) : res_wptr_q;
    tag_rptr_d = tag_pop  ? tag_rptr_q + PW'(1) : tag_rptr_q;
    tag_wptr_d = tag_push ? tag_wptr_q + PW'(1) : tag_wptr_q;
    res_cnt_d  = res_cnt_q + CW'(res_push) - CW'(pop);
    tag_cnt_d  = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
    seq_err_d  = seq_err_q | tag_err | (issue_valid && mult_stall) | (capture && !res_push);
  end

  always_comb begin
    res_rd_d   = res_rd_q;
    res_data_d = res_data_q;
    res_ovf_d  = res_ovf_q;
    tag_rd_d   = tag_rd_q;
    if (res_push) begin
      res_rd_d[res_wptr_q]   = cap_rd;
      res_data_d[res_wptr_q] = product;
      res_ovf_d[res_wptr_q]  = mult_status[0];
    end
    if (tag_push) begin
      tag_rd_d[tag_wptr_q] = issue_rd;
    end
  end

  // Only slots inside each FIFO's live window contribute to the hazard mask.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < res_cnt_q) mask[res_rd_q[res_rptr_q + PW'(i)]] = 1'b1;
      if (CW'(i) < tag_cnt_q) mask[tag_rd_q[tag_rptr_q + PW'(i)]] = 1'b1;
    end
  end

  assign pending_mask = mask;
  assign wb_en        = !res_empty;
  assign wb_addr      = res_empty ? 4'h0  : res_rd_q[res_rptr_q];
  assign wb_data      = res_empty ? 16'h0 : res_data_q[res_rptr_q];
  assign wb_ovf       = res_empty ? 1'b0  : res_ovf_q[res_rptr_q];
  assign seq_err      = seq_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_rptr_q <= '0;
      res_wptr_q <= '0;
      tag_rptr_q <= '0;
      tag_wptr_q <= '0;
      res_cnt_q  <= '0;
      tag_cnt_q  <= '0;
      seq_err_q  <= 1'b0;
    end else begin
      res_rptr_q <= res_rptr_d;
      res_wptr_q <= res_wptr_d;
      tag_rptr_q <= tag_rptr_d;
      tag_wptr_q <= tag_wptr_d;
      res_cnt_q  <= res_cnt_d;
      tag_cnt_q  <= tag_cnt_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Storage is never observed outside the count window, so it needs no reset.
  always_ff @(posedge clk) begin
    res_rd_q   <= res_rd_d;
    res_data_q <= res_data_d;
    res_ovf_q  <= res_ovf_d;
    tag_rd_q   <= tag_rd_d;
  end
endmodule

// File: tb/tb_mult_writeback_queue.sv
// Self-checking bench for mult_writeback_queue: directed table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_mult_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_rd = '0;
  logic [15:0] product = '0;
  logic [1:0]  mult_status = '0;
  logic [15:0] ex_instr = '0;
  logic        wb_grant = 1'b0;
  logic        wb_en, wb_ovf, mult_stall, seq_err;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data, pending_mask;

  mult_writeback_queue #(.DEPTH(DEPTH), .MUL_OPCODE(4'h5)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .product(product), .mult_status(mult_status), .ex_instr(ex_instr),
    .wb_grant(wb_grant), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ovf(wb_ovf), .pending_mask(pending_mask), .mult_stall(mult_stall),
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  rd;
    logic [15:0] data;
    logic        ovf;
  } ent_t;

  typedef struct {
    logic        iv;
    logic [3:0]  ird;
    logic [15:0] prod;
    logic [1:0]  st;
    logic [15:0] ins;
    logic        gr;
    logic [39:0] exp;
  } vec_t;

  ent_t       rq[$];
  logic [3:0] tq[$];
  logic       merr = 1'b0;
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %010h expected %010h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] mk(input logic en, input logic [3:0] a, input logic [15:0] d,
                                     input logic o, input logic [15:0] m, input logic s,
                                     input logic e);
    return {en, a, d, o, m, s, e};
  endfunction

  function automatic logic [39:0] act_vec();
    return {wb_en, wb_addr, wb_data, wb_ovf, pending_mask, mult_stall, seq_err};
  endfunction

  function automatic logic [39:0] model_vec();
    logic [15:0] m;
    logic        s;
    m = '0;
    foreach (rq[i]) m[rq[i].rd] = 1'b1;
    foreach (tq[i]) m[tq[i]] = 1'b1;
    s = (rq.size() + tq.size()) >= DEPTH;
    if (rq.size() > 0) return mk(1'b1, rq[0].rd, rq[0].data, rq[0].ovf, m, s, merr);
    return mk(1'b0, 4'h0, 16'h0, 1'b0, m, s, merr);
  endfunction

  // Reference behaviour of one clock edge, evaluated on pre-edge model contents.
  task automatic model_edge();
    logic stall, pop, cap, full;
    logic [3:0] t;
    ent_t e;
    stall = (rq.size() + tq.size()) >= DEPTH;
    pop   = (rq.size() > 0) && wb_grant;
    cap   = mult_status[1] && (ex_instr[15:12] == 4'h5);
    full  = (rq.size() == DEPTH);
    if (issue_valid && stall) merr = 1'b1;
    if (cap) begin
      if (tq.size() == 0) merr = 1'b1;
      else begin
        t = tq.pop_front();
        if (t != ex_instr[11:8]) merr = 1'b1;
      end
    end
    if (issue_valid && !stall) tq.push_back(issue_rd);
    if (pop) void'(rq.pop_front());
    if (cap) begin
      if (full && !pop) merr = 1'b1;
      else begin
        e.rd = ex_instr[11:8];
        e.data = product;
        e.ovf = mult_status[0];
        rq.push_back(e);
      end
    end
  endtask

  task automatic step(input logic iv, input logic [3:0] ird, input logic [15:0] prod,
                      input logic [1:0] st, input logic [15:0] ins, input logic gr,
                      input string name);
    @(negedge clk);
    issue_valid = iv;
    issue_rd    = ird;
    product     = prod;
    mult_status = st;
    ex_instr    = ins;
    wb_grant    = gr;
    @(posedge clk);
    model_edge();
    #1;
    check(name, act_vec(), model_vec());
  endtask

  task automatic idle(input logic gr, input string name);
    step(1'b0, 4'h0, 16'h0, 2'b00, 16'h0, gr, name);
  endtask

  // Asserts reset from wherever the clock currently is, checks outputs at once.
  task automatic do_reset();
    issue_valid = 1'b0;
    mult_status = 2'b00;
    wb_grant    = 1'b0;
    rst_n       = 1'b0;
    #1;
    check("reset_zero", act_vec(), 40'h0);
    rq.delete();
    tq.delete();
    merr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t       tbl[7];
  logic [3:0] rds[4];
  logic [3:0] wrds[3];

  initial begin
    tbl[0] = '{1'b1, 4'h1, 16'h0000, 2'b00, 16'h0000, 1'b1, mk(0, 4'h0, 16'h0000, 0, 16'h0002, 0, 0)};
    tbl[1] = '{1'b0, 4'h0, 16'h0010, 2'b10, 16'h5123, 1'b1, mk(1, 4'h1, 16'h0010, 0, 16'h0002, 0, 0)};
    tbl[2] = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h0000, 1'b1, mk(0, 4'h0, 16'h0000, 0, 16'h0000, 0, 0)};
    tbl[3] = '{1'b1, 4'h6, 16'h0000, 2'b00, 16'h0000, 1'b0, mk(0, 4'h0, 16'h0000, 0, 16'h0040, 0, 0)};
    tbl[4] = '{1'b0, 4'h0, 16'h7958, 2'b11, 16'h5678, 1'b0, mk(1, 4'h6, 16'h7958, 1, 16'h0040, 0, 0)};
    tbl[5] = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h0000, 1'b0, mk(1, 4'h6, 16'h7958, 1, 16'h0040, 0, 0)};
    tbl[6] = '{1'b0, 4'h0, 16'h0000, 2'b00, 16'h0000, 1'b1, mk(0, 4'h0, 16'h0000, 0, 16'h0000, 0, 0)};
    rds  = '{4'h3, 4'h5, 4'h9, 4'hC};
    wrds = '{4'h1, 4'h2, 4'h4};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      step(tbl[i].iv, tbl[i].ird, tbl[i].prod, tbl[i].st, tbl[i].ins, tbl[i].gr, "table_model");
      check($sformatf("table_%0d", i), act_vec(), tbl[i].exp);
    end

    // Stall, rejected fifth issue, and a full queue.
    for (int k = 0; k < 4; k++) begin
      step(1'b1, rds[k], 16'h0, 2'b00, 16'h0, 1'b0, "fill_issue");
      check("stall_after_issue", {39'h0, mult_stall}, {39'h0, (k == 3)});
    end
    step(1'b1, 4'h7, 16'h0, 2'b00, 16'h0, 1'b0, "fifth_issue");
    check("fifth_issue_err", {39'h0, seq_err}, 40'h1);
    check("fifth_issue_mask", {24'h0, pending_mask}, {24'h0, 16'h1228});
    for (int k = 0; k < 4; k++)
      step(1'b0, 4'h0, 16'hA000 + 16'(k), 2'b10, {4'h5, rds[k], 8'h00}, 1'b0, "fill_capture");
    check("full_head", {wb_en, wb_addr, wb_data, mult_stall}, {18'h0, 1'b1, 4'h3, 16'hA000, 1'b1});
    check("full_mask", {24'h0, pending_mask}, {24'h0, 16'h1228});
    idle(1'b0, "hold_full");
    for (int k = 0; k < 4; k++) begin
      check("drain_head", {19'h0, wb_en, wb_addr, wb_data}, {19'h0, 1'b1, rds[k], 16'hA000 + 16'(k)});
      idle(1'b1, "drain");
    end
    check("drained_empty", {23'h0, wb_en, pending_mask}, 40'h0);

    // Pointer wrap: three more entries through the same slots.
    for (int k = 0; k < 3; k++) step(1'b1, wrds[k], 16'h0, 2'b00, 16'h0, 1'b0, "wrap_issue");
    for (int k = 0; k < 3; k++)
      step(1'b0, 4'h0, 16'hB000 + 16'(k), 2'b10, {4'h5, wrds[k], 8'h00}, 1'b0, "wrap_capture");
    for (int k = 0; k < 3; k++) begin
      check("wrap_head", {19'h0, wb_en, wb_addr, wb_data}, {19'h0, 1'b1, wrds[k], 16'hB000 + 16'(k)});
      idle(1'b1, "wrap_drain");
    end

    // Ignored opcode, tag mismatch, then reset mid-drain.
    do_reset();
    step(1'b0, 4'h0, 16'h1234, 2'b10, 16'h3456, 1'b1, "ignored_op");
    check("ignored_op_en", {39'h0, wb_en}, 40'h0);
    step(1'b1, 4'h2, 16'h0, 2'b00, 16'h0, 1'b0, "mm_issue");
    step(1'b0, 4'h0, 16'h0042, 2'b10, 16'h5323, 1'b0, "mm_capture");
    check("mismatch_err", {39'h0, seq_err}, 40'h1);
    check("mismatch_entry", {20'h0, wb_en, wb_addr, wb_data[14:0]}, {20'h0, 1'b1, 4'h3, 15'h0042});
    step(1'b1, 4'h8, 16'h0, 2'b00, 16'h0, 1'b1, "mid_drain");
    do_reset();
    idle(1'b1, "after_reset");
    check("after_reset_empty", {23'h0, wb_en, pending_mask}, 40'h0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [3:0] op, rd;
      logic gr;
      if (i % 100 == 99) do_reset();
      op = ($urandom_range(0, 3) != 0) ? 4'h5 : 4'($urandom);
      rd = (tq.size() > 0 && $urandom_range(0, 7) != 0) ? tq[0] : 4'($urandom);
      gr = ((i / 25) % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) == 0);
      step(1'($urandom), 4'($urandom), 16'($urandom), 2'($urandom), {op, rd, 8'($urandom)}, gr, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
